// File: rtl/interrupt_sequencer_if.sv
// Bundles the CPU-side signals of interrupt_sequencer.
//   master : CPU/decoder side (drives strobes, IRQ lines, mask writes, acknowledge)
//   slave  : interrupt_sequencer side (drives request, vector and status flags)
// Signals:
//   eix, dix, retix, haltx : one-cycle execute strobes (enable, disable, return, halt)
//   irq[3:0]               : interrupt request lines, bit 0 highest priority
//   mask_wr, mask_data     : mask register write strobe and data (1 = enabled)
//   int_ack                : CPU acknowledge at an instruction boundary
//   int_req, int_vector    : request to CPU and requested/in-service source index
//   ie, halted, in_service : global enable, halted flag, handler-active flag
//   mask                   : current mask register
interface interrupt_sequencer_if;
  logic       eix;
  logic       dix;
  logic       retix;
  logic       haltx;
  logic [3:0] irq;
  logic       mask_wr;
  logic [3:0] mask_data;
  logic       int_ack;
  logic       int_req;
  logic [1:0] int_vector;
  logic       ie;
  logic       halted;
  logic       in_service;
  logic [3:0] mask;

  modport master (
    output eix, dix, retix, haltx, irq, mask_wr, mask_data, int_ack,
    input  int_req, int_vector, ie, halted, in_service, mask
  );

  modport slave (
    input  eix, dix, retix, haltx, irq, mask_wr, mask_data, int_ack,
    output int_req, int_vector, ie, halted, in_service, mask
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: arbitrates four masked interrupt sources, raises a
// request to the CPU, tracks the in-service handler and the halted state.
// Ports:
//   clk   : system clock, all state changes on the rising edge
//   reset : synchronous active-high reset
//   bus   : interrupt_sequencer_if.slave (strobes, IRQ, mask, ack in; status out)
// Configuration macro INTSEQ_EDGE_LATCH_EN:
//   defined   : IRQ rising edges latch into a pending register, cleared on ack
//   undefined : pending follows IRQ directly (level-sensitive)
module interrupt_sequencer (
  input  logic                  clk,
  input  logic                  reset,
  interrupt_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {StRun, StReq, StService, StHalt} state_e;

  state_e     state_q, state_d;
  logic       ie_q, ie_d;
  logic [1:0] vector_q, vector_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] pending;
  logic [3:0] eligible;
  logic [1:0] low_idx;

`ifdef INTSEQ_EDGE_LATCH_EN
  logic [3:0] pending_q, pending_d;
  logic [3:0] irq_prev_q;
  logic [3:0] rise;

  assign rise    = bus.irq & ~irq_prev_q;
  assign pending = pending_q;

  always_comb begin
    pending_d = pending_q | rise;
    // Ack clears the acknowledged source, but a fresh edge in the same cycle wins.
    if (state_q == StReq && bus.int_ack) begin
      pending_d[vector_q] = rise[vector_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= 4'b0000;
      irq_prev_q <= 4'b0000;
    end else begin
      pending_q  <= pending_d;
      irq_prev_q <= bus.irq;
    end
  end
`else
  assign pending = bus.irq;
`endif

  assign eligible = pending & mask_q;

  // Lowest set index wins (bit 0 highest priority).
  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (eligible[i]) low_idx = 2'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    vector_d = vector_q;
    mask_d   = bus.mask_wr ? bus.mask_data : mask_q;
    // DIX dominates EIX.
    if (bus.dix) begin
      ie_d = 1'b0;
    end else if (bus.eix) begin
      ie_d = 1'b1;
    end else begin
      ie_d = ie_q;
    end

    unique case (state_q)
      StRun: begin
        if (bus.haltx) begin
          state_d = StHalt;
        end else if (ie_q && (eligible != 4'b0000)) begin
          state_d  = StReq;
          vector_d = low_idx;
        end
      end
      StReq: begin
        if (bus.int_ack) begin
          state_d = StService;
          ie_d    = 1'b0;
        end else if (bus.dix) begin
          state_d = StRun;
        end
      end
      StService: begin
        if (bus.retix) begin
          state_d = StRun;
          ie_d    = 1'b1;
        end
      end
      StHalt: begin
        if (ie_q && (eligible != 4'b0000)) begin
          state_d  = StReq;
          vector_d = low_idx;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StRun;
      ie_q     <= 1'b0;
      vector_q <= 2'd0;
      mask_q   <= 4'b0000;
    end else begin
      state_q  <= state_d;
      ie_q     <= ie_d;
      vector_q <= vector_d;
      mask_q   <= mask_d;
    end
  end

  assign bus.int_req    = (state_q == StReq);
  assign bus.in_service = (state_q == StService);
  assign bus.halted     = (state_q == StHalt);
  assign bus.int_vector = vector_q;
  assign bus.ie         = ie_q;
  assign bus.mask       = mask_q;

endmodule
